// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width that stays at least one bit wide for WIDTH=1.
  function automatic int unsigned clog2_min1(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Purely combinational 1-bit full adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH cycles.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = clog2_min1(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;

  fa_cell u_fa (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .cin   (r_carry),
    .sum   (w_bit),
    .carry (w_carry)
  );

  // Result bit enters at the MSB; a 1-bit result has nothing to shift down.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_bit;
    end else begin : g_res_wn
      assign w_res_next = {w_bit, r_res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= w_carry;
          r_res_sr <= w_res_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= w_res_next;
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=1, 8 and 17.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s1, c1, busy1, done1, cout1;
  logic [0:0]  a1, b1, sum1;
  logic        s8, c8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        s17, c17, busy17, done17, cout17;
  logic [16:0] a17, b17, sum17;

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(17)) u_dut17 (
    .clk(clk), .rst(rst), .start(s17), .a(a17), .b(b17), .cin(c17),
    .busy(busy17), .done(done17), .sum(sum17), .cout(cout17)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dcnt8    = 0;

  logic [64:0] q1[$];
  logic [64:0] q8[$];
  logic [64:0] q17[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitors: pop expected results on done, and require sum to hold otherwise.
  logic [0:0]  prev1  = '0;
  logic [7:0]  prev8  = '0;
  logic [16:0] prev17 = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev1 = sum1;
    end else begin
      if (done1) begin
        if (q1.size() == 0) check("done1_unexpected", 65'(done1), 65'(0));
        else                check("res1", 65'({cout1, sum1}), q1.pop_front());
      end else begin
        check("hold1", 65'(sum1), 65'(prev1));
      end
      prev1 = sum1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev8 = sum8;
    end else begin
      if (done8) begin
        dcnt8++;
        if (q8.size() == 0) check("done8_unexpected", 65'(done8), 65'(0));
        else                check("res8", 65'({cout8, sum8}), q8.pop_front());
      end else begin
        check("hold8", 65'(sum8), 65'(prev8));
      end
      check("busy_done_excl8", 65'(busy8 & done8), 65'(0));
      prev8 = sum8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev17 = sum17;
    end else begin
      if (done17) begin
        if (q17.size() == 0) check("done17_unexpected", 65'(done17), 65'(0));
        else                 check("res17", 65'({cout17, sum17}), q17.pop_front());
      end else begin
        check("hold17", 65'(sum17), 65'(prev17));
      end
      prev17 = sum17;
    end
  end

  task automatic wait_idle8();
    @(negedge clk);
    for (int k = 0; k < 50 && (busy8 || done8); k++) @(negedge clk);
    if (busy8 || done8) check("idle_timeout8", 65'({busy8, done8}), 65'(0));
  endtask

  task automatic wait_done8(output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done8) check("done_timeout8", 65'(done8), 65'(1));
    t = cyc;
  endtask

  // Full transaction on the WIDTH=8 instance, checking acceptance and latency.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    int n;
    wait_idle8();
    a8 = ia; b8 = ib; c8 = ic;
    q8.push_back(65'(ia) + 65'(ib) + 65'(ic));
    s8 = 1'b1;
    @(posedge clk); #1 s8 = 1'b0;
    check("busy_after_accept8", 65'(busy8), 65'(1));
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency8", 65'(n), 65'(8));
    check("busy_at_done8", 65'(busy8), 65'(0));
  endtask

  initial begin
    int d0;
    int t0, t1, t2;
    s1 = 0; a1 = '0; b1 = '0; c1 = 0;
    s8 = 0; a8 = '0; b8 = '0; c8 = 0;
    s17 = 0; a17 = '0; b17 = '0; c17 = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 65'(busy8), 65'(0));
    check("rst_done8", 65'(done8), 65'(0));
    check("rst_sum8",  65'(sum8),  65'(0));
    check("rst_cout8", 65'(cout8), 65'(0));
    check("rst_sum17", 65'({cout17, sum17}), 65'(0));
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0);
    check("sum_5a_3c", 65'({cout8, sum8}), 65'(9'h096));
    op8(8'hFF, 8'h01, 1'b0);
    check("sum_ff_01", 65'({cout8, sum8}), 65'(9'h100));
    op8(8'hFF, 8'hFF, 1'b1);
    check("sum_ff_ff_c", 65'({cout8, sum8}), 65'(9'h1FF));

    // start re-pulsed and operands changed mid-run must be ignored
    wait_idle8();
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
    q8.push_back(65'(9'h047));
    d0 = dcnt8;
    s8 = 1'b1;
    @(posedge clk); #1 s8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0;
    @(posedge clk); #1 s8 = 1'b0;
    wait_done8(t0);
    repeat (15) @(negedge clk);
    check("single_done8", 65'(dcnt8 - d0), 65'(1));
    check("sum_ignore", 65'({cout8, sum8}), 65'(9'h047));

    // reset at cnt=4 aborts the operation
    wait_idle8();
    a8 = 8'h33; b8 = 8'h44; c8 = 1'b0;
    s8 = 1'b1;
    @(posedge clk); #1 s8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy8", 65'(busy8), 65'(0));
    check("abort_done8", 65'(done8), 65'(0));
    check("abort_sum8",  65'(sum8),  65'(0));
    check("abort_cout8", 65'(cout8), 65'(0));
    d0 = dcnt8;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", 65'(dcnt8 - d0), 65'(0));
    op8(8'h0F, 8'h01, 1'b0);
    check("sum_after_abort", 65'({cout8, sum8}), 65'(9'h010));

    // start held high: back-to-back operations every WIDTH+2 cycles
    wait_idle8();
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0;
    repeat (3) q8.push_back(65'(9'h003));
    d0 = dcnt8;
    s8 = 1'b1;
    wait_done8(t0);
    wait_done8(t1);
    wait_done8(t2);
    s8 = 1'b0;
    check("period_1", 65'(t1 - t0), 65'(10));
    check("period_2", 65'(t2 - t1), 65'(10));
    repeat (15) @(negedge clk);
    check("held_start_dones", 65'(dcnt8 - d0), 65'(3));

    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          @(negedge clk);
          for (int k = 0; k < 50 && (busy1 || done1); k++) @(negedge clk);
          if (busy1 || done1) check("idle_timeout1", 65'({busy1, done1}), 65'(0));
          a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
          q1.push_back(65'(a1) + 65'(b1) + 65'(c1));
          s1 = 1'b1;
          @(posedge clk); #1 s1 = 1'b0;
          a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          wait_idle8();
          a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
          q8.push_back(65'(a8) + 65'(b8) + 65'(c8));
          s8 = 1'b1;
          @(posedge clk); #1 s8 = 1'b0;
          a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          @(negedge clk);
          for (int k = 0; k < 50 && (busy17 || done17); k++) @(negedge clk);
          if (busy17 || done17) check("idle_timeout17", 65'({busy17, done17}), 65'(0));
          a17 = 17'($urandom); b17 = 17'($urandom); c17 = 1'($urandom);
          q17.push_back(65'(a17) + 65'(b17) + 65'(c17));
          s17 = 1'b1;
          @(posedge clk); #1 s17 = 1'b0;
          a17 = 17'($urandom); b17 = 17'($urandom); c17 = 1'($urandom);
        end
      end
    join

    repeat (30) @(negedge clk);
    check("drain1",  65'(q1.size()),  65'(0));
    check("drain8",  65'(q8.size()),  65'(0));
    check("drain17", 65'(q17.size()), 65'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
